// File: rtl/line_steering_controller.sv
// line_steering_controller: PD steering from sampled line position, lost-line search FSM,
// and two registered 10-bit PWM outputs with period-aligned duty shadows.
module line_steering_controller #(
   parameter int CENTER       = 500,
   parameter int BASE_DUTY    = 600,
   parameter int KP           = 1,
   parameter int KD           = 0,
   parameter int SAMPLE_DIV   = 100000,
   parameter int LOST_TIMEOUT = 200,
   parameter int SEARCH_DUTY  = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] position,
   output logic [9:0]  duty_left,
   output logic [9:0]  duty_right,
   output logic        pwm_left,
   output logic        pwm_right,
   output logic [1:0]  state,
   output logic        line_lost
);
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int LW = $clog2(LOST_TIMEOUT + 1);
   localparam logic signed [19:0] KP_S   = 20'(KP);
   localparam logic signed [19:0] KD_S   = 20'(KD);
   localparam logic signed [20:0] BASE_S = 21'(BASE_DUTY);

   typedef enum logic [1:0] {WAIT, TRACK, SEARCH, STOP} state_t;

   state_t             state_q, state_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic               eval_q, eval_d;
   logic               valid_q, valid_d;
   logic signed [11:0] e_q, e_d;
   logic signed [11:0] d_q, d_d;
   logic signed [11:0] e_prev_q, e_prev_d;
   logic               last_left_q, last_left_d;
   logic [LW-1:0]      lost_cnt_q, lost_cnt_d;
   logic [9:0]         duty_left_q, duty_left_d;
   logic [9:0]         duty_right_q, duty_right_d;
   logic [9:0]         pwm_cnt_q, pwm_cnt_d;
   logic [9:0]         shadow_left_q, shadow_left_d;
   logic [9:0]         shadow_right_q, shadow_right_d;
   logic               pwm_left_q, pwm_left_d;
   logic               pwm_right_q, pwm_right_d;

   logic               tick;
   logic               valid;
   logic signed [11:0] e_now;
   logic signed [19:0] corr;
   logic [9:0]         pd_left, pd_right, search_left, search_right;

   function automatic logic [9:0] sat(input logic signed [20:0] v);
      return v < 21'sd0 ? 10'd0 : v > 21'sd1023 ? 10'd1023 : 10'(v);
   endfunction

   // Sample stage: registers the position-derived terms on the tick edge.
   always_comb begin
      tick        = tick_cnt_q == TW'(SAMPLE_DIV - 1);
      valid       = position != 11'd0 && position <= 11'd1000;
      e_now       = $signed({1'b0, position}) - 12'(CENTER);
      tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
      eval_d      = tick;
      valid_d     = tick ? valid : valid_q;
      e_d         = tick ? e_now : e_q;
      d_d         = tick ? (state_q == TRACK ? e_now - e_prev_q : 12'sd0) : d_q;
      e_prev_d    = tick && valid ? e_now : e_prev_q;
      last_left_d = tick && valid && e_now != 12'sd0 ? e_now[11] : last_left_q;
   end

   // Decision stage: one cycle after the tick, update state and duties together.
   always_comb begin
      corr         = KP_S * 20'(e_q) + KD_S * 20'(d_q);
      pd_left      = sat(BASE_S + 21'(corr));
      pd_right     = sat(BASE_S - 21'(corr));
      search_left  = last_left_q ? 10'd0 : 10'(SEARCH_DUTY);
      search_right = last_left_q ? 10'(SEARCH_DUTY) : 10'd0;
      state_d      = state_q;
      lost_cnt_d   = lost_cnt_q;
      if (eval_q) begin
         state_d    = valid_q ? TRACK :
                      state_q == TRACK ? (LOST_TIMEOUT <= 1 ? STOP : SEARCH) :
                      state_q == SEARCH && lost_cnt_q + LW'(1) == LW'(LOST_TIMEOUT) ? STOP : state_q;
         lost_cnt_d = valid_q ? lost_cnt_q :
                      state_q == TRACK ? LW'(1) :
                      state_q == SEARCH ? lost_cnt_q + LW'(1) : lost_cnt_q;
      end
      duty_left_d  = !eval_q ? duty_left_q :
                     state_d == TRACK ? pd_left : state_d == SEARCH ? search_left : 10'd0;
      duty_right_d = !eval_q ? duty_right_q :
                     state_d == TRACK ? pd_right : state_d == SEARCH ? search_right : 10'd0;
   end

   // Shadows only change at the period boundary so a duty update never splits a period.
   always_comb begin
      pwm_cnt_d      = pwm_cnt_q + 10'd1;
      shadow_left_d  = &pwm_cnt_q ? duty_left_q : shadow_left_q;
      shadow_right_d = &pwm_cnt_q ? duty_right_q : shadow_right_q;
      pwm_left_d     = pwm_cnt_q < shadow_left_q;
      pwm_right_d    = pwm_cnt_q < shadow_right_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= WAIT;
         tick_cnt_q     <= '0;
         eval_q         <= 1'b0;
         valid_q        <= 1'b0;
         e_q            <= '0;
         d_q            <= '0;
         e_prev_q       <= '0;
         last_left_q    <= 1'b0;
         lost_cnt_q     <= '0;
         duty_left_q    <= '0;
         duty_right_q   <= '0;
         pwm_cnt_q      <= '0;
         shadow_left_q  <= '0;
         shadow_right_q <= '0;
         pwm_left_q     <= 1'b0;
         pwm_right_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         eval_q         <= eval_d;
         valid_q        <= valid_d;
         e_q            <= e_d;
         d_q            <= d_d;
         e_prev_q       <= e_prev_d;
         last_left_q    <= last_left_d;
         lost_cnt_q     <= lost_cnt_d;
         duty_left_q    <= duty_left_d;
         duty_right_q   <= duty_right_d;
         pwm_cnt_q      <= pwm_cnt_d;
         shadow_left_q  <= shadow_left_d;
         shadow_right_q <= shadow_right_d;
         pwm_left_q     <= pwm_left_d;
         pwm_right_q    <= pwm_right_d;
      end
   end

   assign duty_left  = duty_left_q;
   assign duty_right = duty_right_q;
   assign pwm_left   = pwm_left_q;
   assign pwm_right  = pwm_right_q;
   assign state      = state_q;
   assign line_lost  = state_q[1];
endmodule

// File: tb/tb_line_steering_controller.sv
// tb_line_steering_controller: scoreboard bench driving a KD=0 and a KD=2 instance from the same position stream.
module tb_line_steering_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] position = 11'd1023;
   logic [9:0]  dl_a, dr_a, dl_b, dr_b;
   logic        pl_a, pr_a, pl_b, pr_b, ll_a, ll_b;
   logic [1:0]  st_a, st_b;
   logic [2:0]  tb_cnt;
   int          n_tests = 0;
   int          n_fail = 0;

   typedef struct packed {
      logic [1:0] sa, sb;
      logic       lla, llb;
      logic [9:0] la, ra, lb, rb;
   } vec_t;

   typedef struct packed {
      logic [10:0] pos;
      logic [1:0]  st;
      logic [9:0]  la, ra, lb, rb;
   } step_t;

   vec_t sb[$];

   line_steering_controller #(.KD(0), .SAMPLE_DIV(8), .LOST_TIMEOUT(3)) dut_a (
      .clk(clk), .rst(rst), .position(position), .duty_left(dl_a), .duty_right(dr_a),
      .pwm_left(pl_a), .pwm_right(pr_a), .state(st_a), .line_lost(ll_a));

   line_steering_controller #(.KD(2), .SAMPLE_DIV(8), .LOST_TIMEOUT(3)) dut_b (
      .clk(clk), .rst(rst), .position(position), .duty_left(dl_b), .duty_right(dr_b),
      .pwm_left(pl_b), .pwm_right(pr_b), .state(st_b), .line_lost(ll_b));

   always #5 clk = ~clk;

   // Independent tick reference: SAMPLE_DIV = 8 so a 3-bit counter wraps exactly with the DUT.
   always @(posedge clk) tb_cnt <= rst ? 3'd0 : tb_cnt + 3'd1;

   function automatic vec_t cur();
      return '{st_a, st_b, ll_a, ll_b, dl_a, dr_a, dl_b, dr_b};
   endfunction

   function automatic vec_t mk(logic [1:0] st, logic [9:0] la, logic [9:0] ra, logic [9:0] lb, logic [9:0] rb);
      return '{st, st, st[1], st[1], la, ra, lb, rb};
   endfunction

   function automatic string show(vec_t v);
      return $sformatf("st=%0d/%0d lost=%b/%b kd0 L=%0d R=%0d kd2 L=%0d R=%0d",
                       v.sa, v.sb, v.lla, v.llb, v.la, v.ra, v.lb, v.rb);
   endfunction

   // Holds pos through the next tick cycle, pushes the expectation, returns at T+2 (negedge).
   task automatic drive_tick(input logic [10:0] pos, input vec_t ex, input bit glitch);
      @(negedge clk);
      position = glitch ? 11'd1023 : pos;
      for (int i = 0; i < 16 && tb_cnt != 3'd7; i++) @(negedge clk);
      position = pos;
      sb.push_back(ex);
      @(negedge clk);
      if (glitch) position = 11'd1023;
      @(negedge clk);
      position = pos;
   endtask

   task automatic test_reset();
      vec_t got, ex;
      rst = 1'b1;
      position = 11'd1023;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      got = cur();
      n_tests++;
      if (got !== mk(2'd0, 10'd0, 10'd0, 10'd0, 10'd0) || {pl_a, pr_a, pl_b, pr_b} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset: got %s pwm=%b, want all zero", show(got), {pl_a, pr_a, pl_b, pr_b});
      end
      for (int i = 0; i < 5; i++) begin
         drive_tick(11'd1023, mk(2'd0, 10'd0, 10'd0, 10'd0, 10'd0), 1'b0);
         got = cur();
         ex = sb.pop_front();
         n_tests++;
         if (got !== ex || {pl_a, pr_a, pl_b, pr_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL wait[%0d]: got %s pwm=%b, want %s pwm=0000", i, show(got), {pl_a, pr_a, pl_b, pr_b}, show(ex));
         end
      end
   endtask

   task automatic test_centred();
      vec_t got, ex;
      int cnt[4];
      drive_tick(11'd500, mk(2'd1, 10'd600, 10'd600, 10'd600, 10'd600), 1'b0);
      got = cur();
      ex = sb.pop_front();
      n_tests++;
      if (got !== ex) begin
         n_fail++;
         $display("FAIL centred: got %s, want %s", show(got), show(ex));
      end
      cnt = '{0, 0, 0, 0};
      repeat (1100) @(negedge clk);
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         cnt[0] += int'(pl_a);
         cnt[1] += int'(pr_a);
         cnt[2] += int'(pl_b);
         cnt[3] += int'(pr_b);
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if (cnt[j] != 600) begin
            n_fail++;
            $display("FAIL pwm_high_count[%0d]: got %0d high cycles, want 600", j, cnt[j]);
         end
      end
   endtask

   task automatic test_proportional();
      vec_t got, ex;
      step_t tbl [2] = '{
         '{11'd250,  2'd1, 10'd350,  10'd850, 10'd0,    10'd1023},
         '{11'd1000, 2'd1, 10'd1023, 10'd100, 10'd1023, 10'd0}};
      foreach (tbl[i]) begin
         drive_tick(tbl[i].pos, mk(tbl[i].st, tbl[i].la, tbl[i].ra, tbl[i].lb, tbl[i].rb), 1'b0);
         got = cur();
         ex = sb.pop_front();
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL proportional[%0d]: got %s, want %s", i, show(got), show(ex));
         end
      end
   endtask

   task automatic test_derivative();
      vec_t got, ex;
      step_t tbl [2] = '{
         '{11'd500, 2'd1, 10'd600, 10'd600, 10'd0,    10'd1023},
         '{11'd750, 2'd1, 10'd850, 10'd350, 10'd1023, 10'd0}};
      foreach (tbl[i]) begin
         drive_tick(tbl[i].pos, mk(tbl[i].st, tbl[i].la, tbl[i].ra, tbl[i].lb, tbl[i].rb), 1'b0);
         got = cur();
         ex = sb.pop_front();
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL derivative[%0d]: got %s, want %s", i, show(got), show(ex));
         end
      end
   endtask

   task automatic test_lost_line();
      vec_t got, ex;
      step_t tbl [5] = '{
         '{11'd250,  2'd1, 10'd350, 10'd850, 10'd0,   10'd1023},
         '{11'd1023, 2'd2, 10'd0,   10'd400, 10'd0,   10'd400},
         '{11'd1023, 2'd2, 10'd0,   10'd400, 10'd0,   10'd400},
         '{11'd1023, 2'd3, 10'd0,   10'd0,   10'd0,   10'd0},
         '{11'd500,  2'd1, 10'd600, 10'd600, 10'd600, 10'd600}};
      foreach (tbl[i]) begin
         drive_tick(tbl[i].pos, mk(tbl[i].st, tbl[i].la, tbl[i].ra, tbl[i].lb, tbl[i].rb), 1'b0);
         got = cur();
         ex = sb.pop_front();
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL lost_line[%0d]: got %s, want %s", i, show(got), show(ex));
         end
      end
   endtask

   task automatic test_boundaries();
      vec_t got, ex;
      step_t tbl [5] = '{
         '{11'd0,    2'd2, 10'd0,    10'd400,  10'd0,    10'd400},
         '{11'd1,    2'd1, 10'd101,  10'd1023, 10'd101,  10'd1023},
         '{11'd1001, 2'd2, 10'd0,    10'd400,  10'd0,    10'd400},
         '{11'd1000, 2'd1, 10'd1023, 10'd100,  10'd1023, 10'd100},
         '{11'd600,  2'd1, 10'd700,  10'd500,  10'd0,    10'd1023}};
      foreach (tbl[i]) begin
         drive_tick(tbl[i].pos, mk(tbl[i].st, tbl[i].la, tbl[i].ra, tbl[i].lb, tbl[i].rb), 1'b0);
         got = cur();
         ex = sb.pop_front();
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL boundary[%0d]: got %s, want %s", i, show(got), show(ex));
         end
      end
   endtask

   task automatic test_between_ticks();
      vec_t got, ex;
      drive_tick(11'd450, mk(2'd1, 10'd550, 10'd650, 10'd250, 10'd950), 1'b1);
      got = cur();
      ex = sb.pop_front();
      n_tests++;
      if (got !== ex) begin
         n_fail++;
         $display("FAIL between_ticks: got %s, want %s", show(got), show(ex));
      end
   endtask

   task automatic test_reset_mid();
      vec_t got, ex;
      int k = 0;
      while (k < 2100 && pl_a !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (pl_a !== 1'b1) begin
         n_fail++;
         $display("FAIL pwm_high_wait: pwm_left=%b after %0d cycles, want 1", pl_a, k);
      end
      rst = 1'b1;
      @(negedge clk);
      got = cur();
      n_tests++;
      if (got !== mk(2'd0, 10'd0, 10'd0, 10'd0, 10'd0) || {pl_a, pr_a, pl_b, pr_b} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got %s pwm=%b, want all zero", show(got), {pl_a, pr_a, pl_b, pr_b});
      end
      @(negedge clk);
      rst = 1'b0;
      drive_tick(11'd500, mk(2'd1, 10'd600, 10'd600, 10'd600, 10'd600), 1'b0);
      got = cur();
      ex = sb.pop_front();
      n_tests++;
      if (got !== ex) begin
         n_fail++;
         $display("FAIL resume: got %s, want %s", show(got), show(ex));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_centred();
      test_proportional();
      test_derivative();
      test_lost_line();
      test_boundaries();
      test_between_ticks();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/line_steering_controller.md
# line_steering_controller

Closed-loop steering stage sitting directly downstream of the sensor handler. It samples the 11-bit line position (valid 1..1000, centre 500, 1023 = error) on a periodic control tick and computes a proportional-derivative correction. It drives two 10-bit PWM motor outputs. A lost-line state machine searches toward the last known side, then stops.

## Interface

- CENTER, 500: position setpoint.
- BASE_DUTY, 600: straight-line duty, 0..1023.
- KP, 1: proportional gain, unsigned integer 0..15.
- KD, 0: derivative gain, unsigned integer 0..15.
- SAMPLE_DIV, 100000: clk cycles per control tick, ≥4.
- LOST_TIMEOUT, 200: consecutive invalid ticks in SEARCH before STOP, ≥1.
- SEARCH_DUTY, 400: duty of the spinning wheel in SEARCH.

Ports:

- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- position, input, 11: line position from sensor handler.
- duty_left, output, 10: current left duty.
- duty_right, output, 10: current right duty.
- pwm_left, output, 1: left motor PWM.
- pwm_right, output, 1: right motor PWM.
- state, output, 2: WAIT=0, TRACK=1, SEARCH=2, STOP=3.
- line_lost, output, 1: high in SEARCH or STOP.

## Operation

- tick_cnt runs 0..SAMPLE_DIV-1 and wraps. tick is high when tick_cnt == SAMPLE_DIV-1.
- Valid sample: 1 ≤ position ≤ 1000. Positions 0 and >1000 are invalid.
- Signed arithmetic:
  - e = position − CENTER, 12-bit signed.
  - d = e − e_prev.
  - corr = KP·e + KD·d, 20-bit signed.
  - In TRACK: duty_left = sat(BASE_DUTY + corr), duty_right = sat(BASE_DUTY − corr).
  - sat clamps to [0, 1023].
- e_prev updates on every valid tick. On entry to TRACK from WAIT, SEARCH or STOP, e_prev := e before d is formed, so d = 0 and there is no derivative kick.
- last_left records side: it is set to 1 when a valid e < 0 and cleared when a valid e > 0. It holds when e = 0.
- State transitions are evaluated only on tick:
  - WAIT: duties 0. Valid → TRACK. Invalid → stay.
  - TRACK: PD duties. Invalid → SEARCH with lost_cnt := 1.
  - SEARCH: if last_left, left = 0 and right = SEARCH_DUTY; otherwise left = SEARCH_DUTY and right = 0. Valid → TRACK. Invalid: lost_cnt++. When lost_cnt reaches LOST_TIMEOUT → STOP.
  - STOP: duties 0. Valid → TRACK. Invalid → stay.
- PWM:
  - pwm_cnt is a free-running 10-bit counter, 0..1023, that wraps.
  - Shadow duties load from duty_left/duty_right when pwm_cnt == 1023.
  - pwm_x is registered, = (pwm_cnt < shadow_x).
  - Duty 0 gives constant low. Duty 1023 gives high 1023 of 1024 cycles.

## Timing

- Reset state, all synchronous:
  - state = WAIT.
  - duty_left, duty_right, pwm_left, pwm_right and line_lost = 0.
  - tick_cnt, pwm_cnt, shadows, e_prev, lost_cnt and last_left = 0.
- Reset asserted mid-operation forces every output to 0 on the next edge, including mid-PWM period.
- Control pipeline, with tick high in cycle T:
  - The edge ending T registers the position sample, e and d.
  - The edge ending T+1 registers state, duty_left and duty_right. The new values are visible in cycle T+2.
- PWM latency:
  - A new duty reaches the pins at the first pwm_cnt wrap after T+2.
  - The pin lags the counter compare by one registered cycle.
- position is sampled only on tick. Changes between ticks are ignored.
- Simultaneous tick and pwm_cnt wrap: the shadow loads the old duty. The new duty applies from the following period.

## Test plan

Simulation parameters: SAMPLE_DIV = 8, LOST_TIMEOUT = 3.

- **Reset and WAIT:** rst high 3 cycles with position = 1023, then release for 5 ticks → all outputs 0 and state stays 0.
- **Centred line:** position = 500, KP = 1, KD = 0 → after first tick duty_left = duty_right = 600, state = 1. Next full PWM period is high for exactly 600 of 1024 cycles on both pins.
- **Proportional response and saturation:**
  - position = 250 → duty_left = 350, duty_right = 850.
  - position = 1000 → duty_left = 1023 (saturated), duty_right = 100.
- **Derivative response:** KD = 2, KP = 1. Position 500 then 750 on consecutive ticks → e = 250, d = 250, corr = 750, duty_left = 1023, duty_right = 0.
- **Lost line:** track at 250, then position = 1023:
  - → SEARCH with left = 0, right = 400, line_lost = 1.
  - After 3 invalid ticks → STOP with duties 0.
  - Then position = 500 with KD = 2 → TRACK, 600/600, no derivative kick.
- **Reset mid-operation:** rst pulsed during TRACK with pwm high → next cycle pins 0, state = WAIT. Tracking resumes at the first valid tick after release.
